// File: rtl/score_tracker_pkg.sv
// Shared types and constants for the score/lives tracker.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        WIN,
        LOSE
    } state_t;

    localparam int unsigned LIFE_W = 4;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned      r;
        longint unsigned  p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Game-event and HUD signals between game logic and the score tracker.
// The HighScore signal exists only when SCORE_TRACKER_HIGHSCORE_EN is defined.
interface score_tracker_if #(
    parameter int unsigned WIDTH = 4
);
    logic                          Start;
    logic                          Enable;
    logic                          Hit;
    logic [WIDTH-1:0]              Score;
    logic [score_pkg::LIFE_W-1:0]  Lives;
    logic                          Playing;
    logic                          GameOver;
    logic                          Win;
    logic                          Invuln;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
    logic [WIDTH-1:0]              HighScore;

    modport master (
        output Start, Enable, Hit,
        input  Score, Lives, Playing, GameOver, Win, Invuln, HighScore
    );
    modport slave (
        input  Start, Enable, Hit,
        output Score, Lives, Playing, GameOver, Win, Invuln, HighScore
    );
`else
    modport master (
        output Start, Enable, Hit,
        input  Score, Lives, Playing, GameOver, Win, Invuln
    );
    modport slave (
        input  Start, Enable, Hit,
        output Score, Lives, Playing, GameOver, Win, Invuln
    );
`endif
endinterface

// File: rtl/score_tracker_grace_timer.sv
// Loadable down-counter giving the post-collision grace window.
// busy is registered and equals (count != 0); GRACE = 0 never goes busy.
module grace_timer
    import score_pkg::*;
#(
    parameter int unsigned GRACE = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic run,
    output logic busy
);
    localparam int unsigned CNT_W_RAW = clog2(longint'(GRACE) + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next count: clear beats load beats decrement; counting only while run.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CNT_W'(GRACE);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        busy_d = (cnt_d != '0);
    end

    // Counter and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/score_tracker.sv
// Score and lives tracker for the car game: counts points, removes lives on
// collisions with a grace window, and latches WIN/LOSE until the next Start.
// Optional high-score register: define SCORE_TRACKER_HIGHSCORE_EN.
module score_tracker
    import score_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned WIN_SCORE = 10,
    parameter int unsigned LIVES     = 3,
    parameter int unsigned GRACE     = 50_000_000
) (
    input  logic            CLOCK_50,
    input  logic            Reset,
    score_tracker_if.slave  bus
);
    state_t              state_q, state_d;
    logic [WIDTH-1:0]    score_q, score_d;
    logic [LIFE_W-1:0]   lives_q, lives_d;
    logic                playing_q, playing_d;
    logic                game_over_q, game_over_d;
    logic                win_q, win_d;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
    logic [WIDTH-1:0]    high_score_q, high_score_d;
`endif

    logic                grace_clear;
    logic                grace_load;
    logic                grace_run;
    logic                invuln;
    logic                hit_ok;
    logic                hit_kills;
    logic [WIDTH-1:0]    score_inc;

    grace_timer #(
        .GRACE (GRACE)
    ) u_grace (
        .clk   (CLOCK_50),
        .rst   (Reset),
        .clear (grace_clear),
        .load  (grace_load),
        .run   (grace_run),
        .busy  (invuln)
    );

    // Game rules. The hit is resolved first: a fatal hit drops a coincident
    // point, otherwise the point still applies and a win overrides the hit.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        lives_d     = lives_q;
        grace_clear = 1'b0;
        grace_load  = 1'b0;
        grace_run   = (state_q == PLAY);
        hit_ok      = 1'b0;
        hit_kills   = 1'b0;
        score_inc   = score_q + WIDTH'(1);

        case (state_q)
            PLAY: begin
                hit_ok    = bus.Hit && !invuln;
                hit_kills = hit_ok && (lives_q == LIFE_W'(1));
                if (hit_ok) begin
                    lives_d    = lives_q - LIFE_W'(1);
                    grace_load = 1'b1;
                    if (hit_kills) begin
                        state_d = LOSE;
                    end
                end
                if (bus.Enable && !hit_kills && (score_q < WIDTH'(WIN_SCORE))) begin
                    score_d = score_inc;
                    if (score_inc == WIDTH'(WIN_SCORE)) begin
                        state_d = WIN;
                    end
                end
            end
            default: begin
                if (bus.Start) begin
                    state_d     = PLAY;
                    score_d     = '0;
                    lives_d     = LIFE_W'(LIVES);
                    grace_clear = 1'b1;
                end
            end
        endcase

        playing_d   = (state_d == PLAY);
        game_over_d = (state_d == WIN) || (state_d == LOSE);
        win_d       = (state_d == WIN);
    end

`ifdef SCORE_TRACKER_HIGHSCORE_EN
    // Capture the final score on the edge the game ends, if it is a new best.
    always_comb begin
        high_score_d = high_score_q;
        if ((state_q == PLAY) && game_over_d && (score_d > high_score_q)) begin
            high_score_d = score_d;
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            score_q      <= '0;
            lives_q      <= LIFE_W'(LIVES);
            playing_q    <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
            high_score_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            playing_q    <= playing_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
            high_score_q <= high_score_d;
`endif
        end
    end

    assign bus.Score     = score_q;
    assign bus.Lives     = lives_q;
    assign bus.Playing   = playing_q;
    assign bus.GameOver  = game_over_q;
    assign bus.Win       = win_q;
    assign bus.Invuln    = invuln;
`ifdef SCORE_TRACKER_HIGHSCORE_EN
    assign bus.HighScore = high_score_q;
`endif

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker (WIDTH=4, WIN_SCORE=10, LIVES=3, GRACE=4).
module tb_score_tracker;

    logic clk;
    logic rst;

    score_tracker_if #(.WIDTH(4)) bus();

    score_tracker #(
        .WIDTH     (4),
        .WIN_SCORE (10),
        .LIVES     (3),
        .GRACE     (4)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus.slave)
    );

    typedef struct {
        string      tag;
        logic [3:0] sc;
        logic [3:0] lv;
        logic       pl;
        logic       ov;
        logic       wn;
        logic       iv;
        logic [3:0] hs;
    } exp_t;

    exp_t       sb[$];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] exp_hs   = 4'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_one(input string tag, input string field,
                             input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        check_one(e.tag, "score",    bus.Score,    e.sc);
        check_one(e.tag, "lives",    bus.Lives,    e.lv);
        check_one(e.tag, "playing",  bus.Playing,  e.pl);
        check_one(e.tag, "gameover", bus.GameOver, e.ov);
        check_one(e.tag, "win",      bus.Win,      e.wn);
        check_one(e.tag, "invuln",   bus.Invuln,   e.iv);
`ifdef SCORE_TRACKER_HIGHSCORE_EN
        check_one(e.tag, "highscore", bus.HighScore, e.hs);
`endif
    endtask

    task automatic push_exp(input string tag, input logic [3:0] sc, input logic [3:0] lv,
                            input logic pl, input logic ov, input logic wn, input logic iv);
        exp_t x;
        x.tag = tag; x.sc = sc; x.lv = lv; x.pl = pl;
        x.ov = ov;   x.wn = wn; x.iv = iv; x.hs = exp_hs;
        sb.push_back(x);
    endtask

    // Drive one cycle of inputs, then check outputs just after the edge.
    task automatic step(input logic s, input logic e, input logic h, input string tag,
                        input logic [3:0] sc, input logic [3:0] lv,
                        input logic pl, input logic ov, input logic wn, input logic iv);
        @(negedge clk);
        bus.Start  = s;
        bus.Enable = e;
        bus.Hit    = h;
        push_exp(tag, sc, lv, pl, ov, wn, iv);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic enables(input int n, input logic [3:0] sc0, input logic [3:0] lv,
                           input string tag);
        for (int i = 1; i <= n; i++) begin
            step(0, 1, 0, tag, sc0 + 4'(i), lv, 1, 0, 0, 0);
        end
    endtask

    // Counted hit, then either the full 4-cycle window or the frozen LOSE state.
    task automatic grace_hit(input logic [3:0] sc, input logic [3:0] lv_after, input string tag);
        step(0, 0, 1, tag, sc, lv_after, lv_after != 0, lv_after == 0, 0, 1);
        if (lv_after != 0) begin
            for (int i = 0; i < 3; i++) begin
                step(0, 0, 0, tag, sc, lv_after, 1, 0, 0, 1);
            end
            step(0, 0, 0, tag, sc, lv_after, 1, 0, 0, 0);
        end else begin
            step(0, 0, 0, tag, sc, 0, 0, 1, 0, 1);
        end
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.Enable = 1'b0;
        bus.Hit    = 1'b0;
        rst        = 1'b1;
        #1;
        push_exp("reset", 0, 3, 0, 0, 0, 0);
        compare();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Pulses outside PLAY are ignored.
        step(0, 1, 0, "idle_en",  0, 3, 0, 0, 0, 0);
        step(0, 0, 1, "idle_hit", 0, 3, 0, 0, 0, 0);

        // Game 1: count to WIN_SCORE.
        step(1, 0, 0, "start1", 0, 3, 1, 0, 0, 0);
        enables(9, 0, 3, "count");
        exp_hs = 4'd10;
        step(0, 1, 0, "win",             10, 3, 0, 1, 1, 0);
        step(0, 1, 0, "win_hold",        10, 3, 0, 1, 1, 0);
        step(0, 0, 1, "win_hit_ignored", 10, 3, 0, 1, 1, 0);

        // Game 2: Start ignored in PLAY, grace window, fatal hit with Enable.
        step(1, 0, 0, "start2", 0, 3, 1, 0, 0, 0);
        step(0, 1, 0, "g2_en",  1, 3, 1, 0, 0, 0);
        step(1, 0, 0, "start_in_play", 1, 3, 1, 0, 0, 0);
        step(0, 0, 1, "hit_c0",      1, 2, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c1",    1, 2, 1, 0, 0, 1);
        step(0, 0, 1, "hit_c2_drop", 1, 2, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c3",    1, 2, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c4",    1, 2, 1, 0, 0, 0);
        step(0, 0, 0, "grace_c5",    1, 2, 1, 0, 0, 0);
        step(0, 0, 1, "hit_c6",      1, 1, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c7",    1, 1, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c8",    1, 1, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c9",    1, 1, 1, 0, 0, 1);
        step(0, 0, 0, "grace_c10",   1, 1, 1, 0, 0, 0);
        enables(4, 1, 1, "g2_count");
        step(0, 1, 1, "lose_same", 5, 0, 0, 1, 0, 1);
        step(0, 1, 0, "lose_hold", 5, 0, 0, 1, 0, 1);

        // Game 3: simultaneous Enable and non-fatal Hit reaching WIN_SCORE.
        step(1, 0, 0, "start3", 0, 3, 1, 0, 0, 0);
        grace_hit(0, 2, "g3_hit");
        enables(9, 0, 2, "g3_count");
        step(0, 1, 1, "win_same", 10, 1, 0, 1, 1, 1);

        // Game 4: asynchronous reset mid-game while invulnerable.
        step(1, 0, 0, "start4", 0, 3, 1, 0, 0, 0);
        enables(7, 0, 3, "g4_count");
        step(0, 0, 1, "g4_hit", 7, 2, 1, 0, 0, 1);
        @(negedge clk);
        bus.Hit = 1'b0;
        #2;
        rst    = 1'b1;
        exp_hs = 4'd0;
        #1;
        push_exp("async_rst", 0, 3, 0, 0, 0, 0);
        compare();
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, "start5", 0, 3, 1, 0, 0, 0);

        // High-score games: end at 6, then at 4.
        enables(6, 0, 3, "hs1_count");
        grace_hit(6, 2, "hs1_hit1");
        grace_hit(6, 1, "hs1_hit2");
        exp_hs = 4'd6;
        grace_hit(6, 0, "hs1_lose");
        step(1, 0, 0, "start6", 0, 3, 1, 0, 0, 0);
        enables(4, 0, 3, "hs2_count");
        grace_hit(4, 2, "hs2_hit1");
        grace_hit(4, 1, "hs2_hit2");
        grace_hit(4, 0, "hs2_lose");

        @(negedge clk);
        rst    = 1'b1;
        exp_hs = 4'd0;
        #1;
        push_exp("final_rst", 0, 3, 0, 0, 0, 0);
        compare();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised score and lives tracker for the car game. It counts points on pass pulses and decrements lives on collision pulses, with a post-collision grace window. It declares win or loss and holds the result until a new game is started. It sits between the collision/obstacle logic and the HUD/VGA display and game-control FSM, and replaces the fixed 4-bit, single-life score counter.

## Interface
Parameters:
- WIDTH, 4: score width in bits.
- WIN_SCORE, 10: score that ends the game as a win; legal range 1 to 2^WIDTH-1.
- LIVES, 3: lives at game start; legal range 1 to 15.
- GRACE, 50_000_000: cycles after a counted hit during which further Hit pulses are ignored. 0 disables the window.

Ports:
- CLOCK_50, in, 1: system clock; all state updates on the rising edge.
- Reset, in, 1: asynchronous, active-high reset.
- Start, in, 1: pulse that begins a new game.
- Enable, in, 1: one-cycle pulse that awards one point.
- Hit, in, 1: one-cycle collision pulse.
- Score, out, WIDTH: current score.
- Lives, out, 4: lives remaining.
- Playing, out, 1: high in PLAY.
- GameOver, out, 1: high in WIN or LOSE.
- Win, out, 1: high in WIN only.
- Invuln, out, 1: high while the grace window runs.
- HighScore, out, WIDTH: best score since reset. Present only with the macro defined.

## Operation
- States:
  - IDLE: after reset.
  - PLAY: game running.
  - WIN: terminal.
  - LOSE: terminal.
- Reset values: state IDLE, Score 0, Lives LIVES, grace counter 0, HighScore 0. Playing, GameOver, Win and Invuln are 0.
- Start is accepted in IDLE, WIN or LOSE. On acceptance: Score goes to 0, Lives to LIVES, grace counter clears, state moves to PLAY. Start in PLAY is ignored.
- In PLAY:
  - Enable increments Score by 1.
  - If the incremented value equals WIN_SCORE, state becomes WIN on the same edge.
  - Score never exceeds WIN_SCORE and never wraps.
- In PLAY with Hit and Invuln low:
  - Lives decrements by 1 and the grace counter loads GRACE.
  - If Lives was 1, Lives becomes 0 and state becomes LOSE.
- Hit while Invuln is high is dropped.
- Enable and Hit are ignored outside PLAY.
- Enable and a counted Hit in the same cycle: the Hit is evaluated first.
  - If the Hit causes LOSE, the point is discarded.
  - Otherwise both apply.
  - If the point reaches WIN_SCORE, WIN takes priority.
- Grace counter:
  - Decrements each cycle while nonzero. Invuln = (counter != 0).
  - Freezes when the game leaves PLAY. Clears on Start.
- Reset asserted mid-game forces all reset values immediately. Pulses coincident with Reset are lost.

## Timing
- All outputs are registered.
- Score, Lives and state changes are visible the cycle after the sampling edge of Enable or Hit, giving latency 1.
- GameOver and Win rise in the same cycle in which Score shows WIN_SCORE, or Lives shows 0.
- Invuln rises one cycle after the counted Hit and stays high for exactly GRACE cycles.
- Start to Playing high: 1 cycle.
- Pulses are not edge-detected. A level held for N cycles counts N times, subject to the grace window for Hit.

## Configuration
- SCORE_TRACKER_HIGHSCORE_EN defined:
  - The HighScore port and register exist.
  - On entering WIN or LOSE, HighScore loads Score if Score > HighScore.
  - HighScore persists across Start and clears only on Reset.
- Undefined: no HighScore port, no register, no comparator.

## Structure
- Shared package score_pkg holds:
  - the state enum: IDLE, PLAY, WIN, LOSE;
  - the constant LIFE_W = 4;
  - a clog2 helper used for the grace counter width.
- One sub-module, grace_timer: a loadable down-counter with a busy output, parametrised by GRACE.
- Everything else lives in score_tracker.

## Test plan
- Reset, then Start, then 10 Enable pulses (WIN_SCORE=10) -> Score reaches 10, Win=1 and GameOver=1 in the same cycle. An 11th Enable leaves Score at 10.
- GRACE=4, LIVES=3, Hit on cycles 0, 2 and 6 after Start -> Lives 3→2 at cycle 1, the Hit at cycle 2 is ignored, Lives 2→1 at cycle 7, Invuln is high for 4 cycles after each counted Hit.
- Lives=1, Enable and Hit in the same cycle with Score=5 -> state LOSE, Score stays 5, Lives 0.
- Score=9 (WIN_SCORE=10), Lives=2, simultaneous Enable and Hit -> Win=1, Score=10, Lives=1.
- Reset asserted mid-game with Score=7 and Invuln high -> all outputs at reset values asynchronously. Start then begins a fresh game with Lives=LIVES.
- Macro defined: game 1 ends at Score 6, game 2 at Score 4 -> HighScore is 6 after both. After Reset, HighScore is 0.
